axi_lite_wrr_scheduler: RTL and testbench

AXI_LITE_WRR_SCHEDULER -- requirements
Module: axi_lite_wrr_scheduler

---
 rtl/axi_lite_wrr_scheduler.sv | 114 +++++++++++
 tb/tb_axi_lite_wrr_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_wrr_scheduler.sv
// Weighted round-robin arbiter granting one of N AXI-Lite masters access to a shared slave.
// A grant is held until the address handshake and the slave is owned until the response completes.
module axi_lite_wrr_scheduler #(
    parameter int N        = 4,
    parameter int WEIGHT_W = 4,
    localparam int ID_W    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*WEIGHT_W-1:0] weight,
    input  logic                  addr_hs,
    input  logic                  done,
    output logic [N-1:0]          grant,
    output logic [ID_W-1:0]       grant_idx,
    output logic                  busy,
    output logic [WEIGHT_W-1:0]   credit
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    logic [1:0]      state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;
    logic            cand_vld;
    logic [ID_W-1:0] ptr_next;

    // A zero weight still earns one transaction per round.
    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [N*WEIGHT_W-1:0] w,
                                                       input logic [ID_W-1:0] i);
        logic [WEIGHT_W-1:0] v;
        v = w[i*WEIGHT_W +: WEIGHT_W];
        return (v == '0) ? WEIGHT_W'(1) : v;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scan downward so the requester closest to ptr (smallest offset) wins.
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                cand     = ID_W'((int'(ptr) + k) % N);
                cand_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = (grant_idx == ID_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            ptr       <= '0;
            credit    <= WEIGHT_W'(1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cand_vld) begin
                        grant     <= onehot(cand);
                        grant_idx <= cand;
                        state     <= ST_GRANT;
                        if (cand != ptr) begin
                            ptr    <= cand;
                            credit <= eff_weight(weight, cand);
                        end
                    end
                end
                ST_GRANT: begin
                    if (addr_hs) begin
                        grant <= '0;
                        busy  <= 1'b1;
                        state <= ST_BUSY;
                        // Last credit spent: hand the pointer on and preload its budget.
                        if (credit <= WEIGHT_W'(1)) begin
                            ptr    <= ptr_next;
                            credit <= eff_weight(weight, ptr_next);
                        end else begin
                            credit <= credit - 1'b1;
                        end
                    end else if (!req[grant_idx]) begin
                        grant <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_wrr_scheduler.sv
// Bench for axi_lite_wrr_scheduler: cycle-level vector table, grant-order scoreboard
// for the weighted rotation, and per-cycle grant/busy invariant monitoring.
module tb_axi_lite_wrr_scheduler;
    localparam int N    = 4;
    localparam int WW   = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*WW-1:0] weight = '0;
    logic            addr_hs = 1'b0;
    logic            done = 1'b0;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_idx;
    logic            busy;
    logic [WW-1:0]   credit;

    int checks = 0;
    int errors = 0;

    axi_lite_wrr_scheduler #(.N(N), .WEIGHT_W(WW)) dut (
        .clk(clk), .rst(rst), .req(req), .weight(weight), .addr_hs(addr_hs), .done(done),
        .grant(grant), .grant_idx(grant_idx), .busy(busy), .credit(credit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       addr_hs;
        logic       done;
        logic [3:0] exp_grant;
        int         exp_idx;
        logic       exp_busy;
        int         exp_credit;
    } vec_t;

    typedef struct {
        int idx;
        int credit;
    } exp_t;

    vec_t vecs[18];
    exp_t sb[$];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic hs, input logic dn,
                                input logic [3:0] g, input int idx, input logic b, input int cr);
        vec_t v;
        v.rst = r; v.req = rq; v.addr_hs = hs; v.done = dn;
        v.exp_grant = g; v.exp_idx = idx; v.exp_busy = b; v.exp_credit = cr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; addr_hs = 1'b0; done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_txns(input int count);
        exp_t e;
        int   w;
        for (int t = 0; t < count; t++) begin
            w = 0;
            while (grant == '0 && w < 20) begin
                tick();
                w++;
            end
            if (grant == '0) begin
                checks++;
                errors++;
                $display("FAIL grant_timeout: got no grant, expected grant for txn %0d", t);
                return;
            end
            e = sb.pop_front();
            chk("wrr_grant", int'(grant), 1 << e.idx);
            chk("wrr_idx", int'(grant_idx), e.idx);
            chk("wrr_credit", int'(credit), e.credit);
            addr_hs = 1'b1;
            tick();
            addr_hs = 1'b0;
            chk("wrr_busy_set", int'(busy), 1);
            chk("wrr_grant_clr", int'(grant), 0);
            tick();
            chk("wrr_busy_hold", int'(busy), 1);
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("wrr_busy_clr", int'(busy), 0);
        end
    endtask

    // Invariants sampled mid-cycle: one-hot grant, never granted while busy, held grant stable.
    logic [N-1:0] g_prev;
    logic         hold_prev = 1'b0;
    always @(negedge clk) begin
        if (hold_prev) begin
            checks++;
            if (grant !== g_prev) begin
                errors++;
                $display("FAIL grant_stable: got %b, expected %b", grant, g_prev);
            end
        end
        if (!rst) begin
            checks++;
            if (!$onehot0(grant) || (|grant && busy)) begin
                errors++;
                $display("FAIL grant_busy_excl: got grant=%b busy=%b, expected onehot0 and exclusive", grant, busy);
            end
        end
        g_prev    = grant;
        hold_prev = (|grant) && req[grant_idx] && !addr_hs && !rst;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst req      hs dn  grant    idx busy cr
        vecs[0]  = mk(0, 4'b0100, 0, 0, 4'b0100, 2, 0, 5);
        vecs[1]  = mk(0, 4'b0100, 0, 1, 4'b0100, 2, 0, 5);
        vecs[2]  = mk(0, 4'b0000, 0, 0, 4'b0000, 2, 0, 5);
        vecs[3]  = mk(0, 4'b0000, 1, 0, 4'b0000, 2, 0, 5);
        vecs[4]  = mk(0, 4'b0100, 0, 1, 4'b0100, 2, 0, 5);
        vecs[5]  = mk(0, 4'b1111, 1, 1, 4'b0000, 2, 1, 4);
        vecs[6]  = mk(0, 4'b1111, 1, 0, 4'b0000, 2, 1, 4);
        vecs[7]  = mk(0, 4'b1111, 0, 0, 4'b0000, 2, 1, 4);
        vecs[8]  = mk(0, 4'b1111, 0, 1, 4'b0000, 2, 0, 4);
        vecs[9]  = mk(0, 4'b1111, 0, 0, 4'b0100, 2, 0, 4);
        vecs[10] = mk(0, 4'b1111, 1, 0, 4'b0000, 2, 1, 3);
        vecs[11] = mk(0, 4'b0000, 0, 1, 4'b0000, 2, 0, 3);
        vecs[12] = mk(0, 4'b0010, 0, 0, 4'b0010, 1, 0, 1);
        vecs[13] = mk(0, 4'b0010, 1, 0, 4'b0000, 1, 1, 5);
        vecs[14] = mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 1);
        vecs[15] = mk(0, 4'b0001, 0, 0, 4'b0001, 0, 0, 1);
        vecs[16] = mk(1, 4'b0001, 0, 0, 4'b0000, 0, 0, 1);
        vecs[17] = mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 1);

        // Table run: weight[0]=3, weight[1]=0, weight[2]=5, weight[3]=0.
        weight = 16'h0503;
        req    = '0;
        rst    = 1'b1;
        tick();
        tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_idx", int'(grant_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_credit", int'(credit), 1);
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            rst     = vecs[i].rst;
            req     = vecs[i].req;
            addr_hs = vecs[i].addr_hs;
            done    = vecs[i].done;
            tick();
            chk($sformatf("vec%0d_grant", i), int'(grant), int'(vecs[i].exp_grant));
            chk($sformatf("vec%0d_idx", i), int'(grant_idx), vecs[i].exp_idx);
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_credit", i), int'(credit), vecs[i].exp_credit);
        end
        req = '0; addr_hs = 1'b0; done = 1'b0; rst = 1'b0;

        // Equal weights, all requesting: plain rotation with wrap.
        weight = 16'h1111;
        req    = 4'b1111;
        do_reset();
        for (int i = 0; i < 5; i++) sb.push_back('{idx: i % N, credit: 1});
        run_txns(5);
        chk("rr_sb_empty", sb.size(), 0);

        // weight[0]=3 against requester 1: after the first lap, 0 gets three slots per round.
        weight = 16'h1113;
        req    = 4'b0011;
        do_reset();
        sb.push_back('{idx: 0, credit: 1});
        sb.push_back('{idx: 1, credit: 1});
        for (int r = 0; r < 2; r++) begin
            sb.push_back('{idx: 0, credit: 3});
            sb.push_back('{idx: 0, credit: 2});
            sb.push_back('{idx: 0, credit: 1});
            sb.push_back('{idx: 1, credit: 1});
        end
        run_txns(10);
        chk("wrr_sb_empty", sb.size(), 0);

        req = '0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
